wm_dist_monitor: RTL and testbench

//  Downstream consumer and scheduler for the ultrasonic ranging controller.
//  - Issues periodic one-cycle distChkEn requests.
//  - Captures each usDist/usDistEn result; flags a missing result as a timeout.
//  - Smooths samples with an optional 4-tap moving average.
//  - Drives objNear through a hysteresis comparator for the washer door/load logic.

---
 rtl/wm_dist_monitor.sv | 160 ++++++++++++++++
 tb/tb_wm_dist_monitor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wm_dist_monitor.sv
// Periodic ranging scheduler: issues distChkEn requests, captures results or flags timeouts,
// smooths samples and drives a hysteresis near/far flag. Define WM_DIST_AVG_EN for the 4-tap average.
module wm_dist_monitor #(
    parameter int          PERIOD_MS  = 100,
    parameter int          TIMEOUT_MS = 60,
    parameter logic [7:0]  NEAR_TH    = 8'd20,
    parameter logic [7:0]  FAR_TH     = 8'd30
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       monEn,
    input  logic       clkCnt_1msEnd,
    input  logic       usDistEn,
    input  logic [7:0] usDist,
    output logic       distChkEn,
    output logic       distVld,
    output logic [7:0] distAvg,
    output logic       objNear,
    output logic       objNearChg,
    output logic       usTimeout,
    output logic       usErr
);

    localparam int MAXMS = (PERIOD_MS > TIMEOUT_MS) ? PERIOD_MS : TIMEOUT_MS;
    localparam int CW    = $clog2(MAXMS) + 1;
    localparam logic [CW-1:0] PER_LAST = CW'(PERIOD_MS - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_MS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cap;
    logic [7:0]      avg;
    logic            distVld_q, objNear_q, objNearChg_q, usErr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap       = 1'b0;
        usTimeout = 1'b0;
        if (!monEn) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the timeout tick takes priority over the timeout.
                    if (usDistEn) begin
                        cap     = 1'b1;
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end else if (clkCnt_1msEnd) begin
                        if (cnt_q == TO_LAST) begin
                            usTimeout = 1'b1;
                            cnt_d     = '0;
                            state_d   = S_HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (clkCnt_1msEnd) begin
                        if (cnt_q == PER_LAST) begin
                            cnt_d   = '0;
                            state_d = S_REQ;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign distChkEn = (state_q == S_REQ);

`ifdef WM_DIST_AVG_EN
    logic [3:0][7:0] buf_q;
    logic            fill_q;
    logic [9:0]      sum;

    // An empty buffer is primed with the first sample so the average starts exact.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_q  <= '0;
            fill_q <= 1'b0;
        end else if (cap) begin
            buf_q  <= fill_q ? {buf_q[2:0], usDist} : {4{usDist}};
            fill_q <= 1'b1;
        end else if (!monEn) begin
            fill_q <= 1'b0;
        end
    end

    always_comb begin
        sum = {2'b00, buf_q[0]} + {2'b00, buf_q[1]} + {2'b00, buf_q[2]} + {2'b00, buf_q[3]};
        avg = 8'(sum >> 2);
    end
`else
    logic [7:0] raw_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    raw_q <= '0;
        else if (cap) raw_q <= usDist;
    end

    assign avg = raw_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            distVld_q    <= 1'b0;
            objNear_q    <= 1'b0;
            objNearChg_q <= 1'b0;
            usErr_q      <= 1'b0;
        end else begin
            distVld_q    <= cap;
            objNearChg_q <= 1'b0;
            if (distVld_q) begin
                if (!objNear_q && avg <= NEAR_TH) begin
                    objNear_q    <= 1'b1;
                    objNearChg_q <= 1'b1;
                end else if (objNear_q && avg >= FAR_TH) begin
                    objNear_q    <= 1'b0;
                    objNearChg_q <= 1'b1;
                end
            end
            if (cap)            usErr_q <= 1'b0;
            else if (usTimeout) usErr_q <= 1'b1;
        end
    end

    assign distVld    = distVld_q;
    assign distAvg    = avg;
    assign objNear    = objNear_q;
    assign objNearChg = objNearChg_q;
    assign usErr      = usErr_q;

endmodule

// File: tb/tb_wm_dist_monitor.sv
// Randomized transaction bench for wm_dist_monitor with an event-time reference model.
module tb_wm_dist_monitor;

    localparam int PER = 3, TMO = 2;
    localparam logic [7:0] NEAR = 8'd20, FAR = 8'd30;

    logic       clk = 1'b0, rstn = 1'b0, monEn = 1'b0, clkCnt_1msEnd = 1'b0, usDistEn = 1'b0;
    logic [7:0] usDist = '0;
    logic       distChkEn, distVld, objNear, objNearChg, usTimeout, usErr;
    logic [7:0] distAvg;

    wm_dist_monitor #(.PERIOD_MS(PER), .TIMEOUT_MS(TMO), .NEAR_TH(NEAR), .FAR_TH(FAR)) dut (
        .clk(clk), .rstn(rstn), .monEn(monEn), .clkCnt_1msEnd(clkCnt_1msEnd),
        .usDistEn(usDistEn), .usDist(usDist), .distChkEn(distChkEn), .distVld(distVld),
        .distAvg(distAvg), .objNear(objNear), .objNearChg(objNearChg),
        .usTimeout(usTimeout), .usErr(usErr)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0;
    bit mon_drv = 1'b0;

    // Expected event cycles and output values.
    int  req_cyc = -100, to_cyc = -100, cap_cyc = -100;
    int  m_avg = 0, e_avg = 0;
    bit  e_near = 0, e_err = 0, e_vld = 0, e_chg = 0;
`ifdef WM_DIST_AVG_EN
    int  hist[$];
    bit  m_fill = 0;
`endif

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, act, exp);
        end
    endtask

    // Cycle of the n-th 1 ms tick strictly after cycle a (ticks fall on cyc % 10 == 9).
    function automatic int nth_tick(input int a, input int n);
        int c;
        c = a + 1;
        c += (19 - c % 10) % 10;
        return c + 10 * (n - 1);
    endfunction

    function automatic void model_capture(input int v);
`ifdef WM_DIST_AVG_EN
        int s;
        if (!m_fill) begin
            hist.delete();
            repeat (4) hist.push_back(v);
            m_fill = 1;
        end else begin
            void'(hist.pop_front());
            hist.push_back(v);
        end
        s = 0;
        foreach (hist[i]) s += hist[i];
        m_avg = s / 4;
`else
        m_avg = v;
`endif
    endfunction

    function automatic void model_flush();
`ifdef WM_DIST_AVG_EN
        m_fill = 0;
`endif
    endfunction

    function automatic void model_reset();
        req_cyc = -100; to_cyc = -100; cap_cyc = -100;
        e_avg = 0; e_near = 0; e_err = 0;
        model_flush();
    endfunction

    task automatic run_cycle(input bit en, input logic [7:0] v, input bit cap);
        bit nxt;
        @(posedge clk); #1;
        clkCnt_1msEnd = (cyc % 10 == 9);
        monEn         = mon_drv;
        usDistEn      = en;
        usDist        = v;
        if (cap) begin
            model_capture(int'(v));
            cap_cyc = cyc;
        end
        @(negedge clk);
        e_vld = (cyc == cap_cyc + 1);
        if (e_vld) begin
            e_avg = m_avg;
            e_err = 0;
        end
        e_chg = 0;
        if (cyc == cap_cyc + 2) begin
            nxt   = e_near ? (e_avg < int'(FAR)) : (e_avg <= int'(NEAR));
            e_chg = (nxt != e_near);
            e_near = nxt;
        end
        if (cyc == to_cyc + 1) e_err = 1;
        chk("distChkEn",  32'(distChkEn),  32'(cyc == req_cyc));
        chk("usTimeout",  32'(usTimeout),  32'(cyc == to_cyc));
        chk("distVld",    32'(distVld),    32'(e_vld));
        chk("distAvg",    32'(distAvg),    32'(e_avg));
        chk("objNear",    32'(objNear),    32'(e_near));
        chk("objNearChg", 32'(objNearChg), 32'(e_chg));
        chk("usErr",      32'(usErr),      32'(e_err));
    endtask

    function automatic logic [7:0] pick();
        return ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 60));
    endfunction

    int dir[12] = '{40, 40, 40, 40, 8, 12, 12, 12, 12, 40, 40, 40};

    initial begin
        int R, tmo, S, D, kind;
        logic [7:0] v;
        repeat (3) run_cycle(1'b0, 8'h00, 1'b0);
        rstn    = 1'b1;
        mon_drv = 1'b1;
        req_cyc = cyc + 2;
        for (int t = 0; t < 45; t++) begin
            if (t == 30) begin
                rstn    = 1'b0;
                mon_drv = 1'b0;
                model_reset();
                repeat (2) run_cycle(1'b1, 8'd5, 1'b0);
                rstn = 1'b1;
                repeat (3) run_cycle(1'b0, 8'h00, 1'b0);
                mon_drv = 1'b1;
                req_cyc = cyc + 2;
            end
            // Hold/idle cycles up to the request; stray strobes here must be ignored.
            while (cyc + 1 < req_cyc)
                run_cycle($urandom_range(0, 7) == 0, 8'($urandom), 1'b0);
            run_cycle(1'b0, 8'h00, 1'b0);
            R   = cyc;
            tmo = nth_tick(R, TMO);
            if (t < 12)       kind = 0;
            else if (t == 12) kind = 3;
            else if (t == 13) kind = 4;
            else if (t == 14) kind = 5;
            else              kind = $urandom_range(0, 5);
            v = (t < 12) ? 8'(dir[t]) : pick();
            case (kind)
                3: begin
                    to_cyc = tmo;
                    while (cyc < tmo) run_cycle(1'b0, 8'($urandom), 1'b0);
                    req_cyc = nth_tick(tmo, PER) + 1;
                end
                5: begin
                    D = $urandom_range(R + 1, tmo - 1);
                    while (cyc + 1 < D) run_cycle(1'b0, 8'($urandom), 1'b0);
                    mon_drv = 1'b0;
                    req_cyc = -100;
                    model_flush();
                    run_cycle(1'b0, 8'h00, 1'b0);
                    repeat ($urandom_range(1, 4)) run_cycle(1'b1, pick(), 1'b0);
                    mon_drv = 1'b1;
                    req_cyc = cyc + 2;
                end
                default: begin
                    S = (kind == 4) ? tmo : $urandom_range(R + 1, tmo - 1);
                    while (cyc + 1 < S) run_cycle(1'b0, 8'($urandom), 1'b0);
                    run_cycle(1'b1, v, 1'b1);
                    req_cyc = nth_tick(cyc, PER) + 1;
                end
            endcase
        end
        repeat (4) run_cycle(1'b0, 8'h00, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
